butterfly_switch_stage: RTL and testbench
=========================================

BUTTERFLY_SWITCH_STAGE -- requirements
Module: butterfly_switch_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, giving the node address width.
REQ-002 SHALL have parameter LEVEL, default 0, giving the address bit this stage routes on; legal range 0..ADDR_W-1.
REQ-003 SHALL have parameter DATA_W, default 32, giving the payload width.
REQ-004 SHALL have parameter DEPTH, default 4, giving input FIFO entries; must be a power of 2 and at least 2.
REQ-005 SHALL have parameter ROUTE_MODE, default 0: 0 routes on src[LEVEL]^dest[LEVEL]; 1 routes on dest[LEVEL].
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 2 bits: per-input flit valid.
REQ-009 SHALL have port in_ready, output, 2 bits: per-input FIFO not full.
REQ-010 SHALL have ports in_src and in_dest, input, 2*ADDR_W bits each: per-input addresses, input i at slice [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port in_data, input, 2*DATA_W bits: per-input payload.
REQ-012 SHALL have port out_valid, output, 2 bits: per-output flit valid.
REQ-013 SHALL have port out_ready, input, 2 bits: per-output downstream accept.
REQ-014 SHALL have ports out_src, out_dest and out_data, outputs, sized as the input equivalents: per-output flit fields.
REQ-015 SHALL have port fifo_cnt, output, 2*($clog2(DEPTH)+1) bits: per-input occupancy.

Function
REQ-016 Input i SHALL accept a flit when in_valid[i] and in_ready[i] are both high at a rising edge.
REQ-017 in_ready[i] SHALL equal (fifo_cnt[i] < DEPTH), computed from registered count only; a same-cycle pop SHALL NOT raise it.
REQ-018 Push and pop on the same FIFO in the same cycle SHALL leave its count unchanged and SHALL lose no data.
REQ-019 Each FIFO head SHALL request the output selected by ROUTE_MODE from its own src/dest fields.
REQ-020 Each output SHALL hold an output register; it loads when empty or when out_valid and out_ready are both high.
REQ-021 Per-output arbitration SHALL be round-robin over the two inputs: the pointer moves to the other input after each grant; a lone requester always wins.
REQ-022 Heads requesting different outputs SHALL both be granted in the same cycle.
REQ-023 The arbitration loser SHALL stay at its FIFO head unchanged; no flit is ever dropped or duplicated.
REQ-024 A flit sampled at edge k into an empty, unblocked path SHALL appear on out_* with out_valid high after edge k+1.
REQ-025 Sustained throughput SHALL be 1 flit/cycle per output.
REQ-026 While out_valid is high and out_ready is low, out_src, out_dest and out_data SHALL remain stable.
REQ-027 Per-input flit order SHALL be preserved on every output.

Reset
REQ-028 When rst is low, the block SHALL immediately clear out_valid to 0, FIFO pointers and counts to 0, and both round-robin pointers to input 0.
REQ-029 out_src, out_dest and out_data SHALL reset to 0.
REQ-030 in_ready SHALL read 2'b11 after reset is released.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered flits.

Structure
REQ-032 Package butterfly_pkg SHALL hold the flit field offsets and widths and the route-select function shared with other stages.
REQ-033 The input FIFO SHALL be a sub-module, bfly_fifo, instantiated twice.

Verification (ADDR_W=3, LEVEL=1, DEPTH=4)
REQ-034 Mode 0: in0 carries src=000, dest=010, data=0xA5 at edge k -> out_valid[1]=1 after edge k+1 with data 0xA5; out_valid[0] stays 0.
REQ-035 in0 and in1 each carry 4 flits to output 0, with out_ready=2'b11 -> output 0 delivers in the order in0, in1, in0, in1, in0, in1, in0, in1 on consecutive cycles.
REQ-036 out_ready[1]=0 while in0 pushes flits to output 1 -> exactly 5 accepted (1 in the output register, 4 in the FIFO); in_ready[0]=0 on the 6th; data stable; all 5 are delivered in order after out_ready rises.
REQ-037 in0 sends to output 0 and in1 sends to output 1 at the same edge -> both outputs valid after the next edge.
REQ-038 rst pulsed low with 3 flits buffered -> out_valid=0 and fifo_cnt=0 immediately; none of the 3 flits ever emerges.
REQ-039 ROUTE_MODE=1 with src=010, dest=010 -> output 1 (in mode 0 the same flit goes to output 0).

Source files
------------

// File: rtl/butterfly_pkg.sv
// Shared definitions for butterfly switch stages: flit layout and route select.
package butterfly_pkg;

  localparam int unsigned NUM_PORTS    = 2;
  localparam int unsigned FLIT_SRC_OFF = 0;

  typedef enum logic {
    ROUTE_XOR  = 1'b0,
    ROUTE_DEST = 1'b1
  } route_mode_e;

  // Flit layout is {data, dest, src}, src at the LSBs.
  function automatic int unsigned flit_dest_off(input int unsigned addr_w);
    return addr_w;
  endfunction

  function automatic int unsigned flit_data_off(input int unsigned addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int unsigned flit_w(input int unsigned addr_w, input int unsigned data_w);
    return 2 * addr_w + data_w;
  endfunction

  // Output port a flit heads to, given the address bits of the routed level.
  function automatic logic route_sel(input route_mode_e mode, input logic src_bit,
                                     input logic dest_bit);
    return (mode == ROUTE_DEST) ? dest_bit : (src_bit ^ dest_bit);
  endfunction

endpackage

// File: rtl/butterfly_switch_stage_fifo.sv
// Input FIFO for one switch input; ready depends only on the registered count.
module bfly_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] cnt,
  output logic          ready,
  output logic          nonempty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign ready    = (cnt_q < CW'(DEPTH));
  assign nonempty = (cnt_q != '0);
  assign push_ok  = push && ready;
  assign pop_ok   = pop && nonempty;
  assign head     = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;

  // Next pointers and occupancy; push and pop together leave the count as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage array; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/butterfly_switch_stage.sv
// 2x2 butterfly switch stage: two input FIFOs, round-robin arbitration per output,
// one registered flit per output.
module butterfly_switch_stage
  import butterfly_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int LEVEL      = 0,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int ROUTE_MODE = 0,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in_valid,
  output logic [1:0]          in_ready,
  input  logic [2*ADDR_W-1:0] in_src,
  input  logic [2*ADDR_W-1:0] in_dest,
  input  logic [2*DATA_W-1:0] in_data,
  output logic [1:0]          out_valid,
  input  logic [1:0]          out_ready,
  output logic [2*ADDR_W-1:0] out_src,
  output logic [2*ADDR_W-1:0] out_dest,
  output logic [2*DATA_W-1:0] out_data,
  output logic [2*CW-1:0]     fifo_cnt
);

  localparam int FW       = int'(flit_w(ADDR_W, DATA_W));
  localparam int DEST_OFF = int'(flit_dest_off(ADDR_W));
  localparam int DATA_OFF = int'(flit_data_off(ADDR_W));
  localparam route_mode_e MODE = (ROUTE_MODE != 0) ? ROUTE_DEST : ROUTE_XOR;

  logic [FW-1:0] head      [NUM_PORTS];
  logic [1:0]    nonempty;
  logic [1:0]    pop;
  logic [1:0]    port_sel;
  logic [FW-1:0] out_flit_q [NUM_PORTS];
  logic [FW-1:0] out_flit_d [NUM_PORTS];
  logic [1:0]    out_valid_q, out_valid_d;
  logic [1:0]    rr_q, rr_d;

  for (genvar i = 0; i < 2; i++) begin : g_in
    bfly_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[i]),
      .push_data ({in_data[i*DATA_W +: DATA_W], in_dest[i*ADDR_W +: ADDR_W],
                   in_src[i*ADDR_W +: ADDR_W]}),
      .pop       (pop[i]),
      .head      (head[i]),
      .cnt       (fifo_cnt[i*CW +: CW]),
      .ready     (in_ready[i]),
      .nonempty  (nonempty[i])
    );

    assign port_sel[i] = route_sel(MODE, head[i][FLIT_SRC_OFF + LEVEL], head[i][DEST_OFF + LEVEL]);

    assign out_valid[i]                  = out_valid_q[i];
    assign out_src[i*ADDR_W +: ADDR_W]   = out_flit_q[i][FLIT_SRC_OFF +: ADDR_W];
    assign out_dest[i*ADDR_W +: ADDR_W]  = out_flit_q[i][DEST_OFF +: ADDR_W];
    assign out_data[i*DATA_W +: DATA_W]  = out_flit_q[i][DATA_OFF +: DATA_W];
  end

  // Per-output round-robin grant into the output register; the loser keeps its head.
  always_comb begin
    logic req0, req1, gnt, sel;
    pop         = '0;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    req0        = 1'b0;
    req1        = 1'b0;
    gnt         = 1'b0;
    sel         = 1'b0;
    for (int o = 0; o < 2; o++) begin
      out_flit_d[o] = out_flit_q[o];
      req0 = nonempty[0] && (port_sel[0] == 1'(o));
      req1 = nonempty[1] && (port_sel[1] == 1'(o));
      gnt  = 1'b0;
      sel  = 1'b0;
      if (!out_valid_q[o] || out_ready[o]) begin
        if (req0 && req1) begin
          gnt = 1'b1;
          sel = rr_q[o];
        end else if (req0 || req1) begin
          gnt = 1'b1;
          sel = req1;
        end
        if (gnt) begin
          out_flit_d[o]  = head[sel];
          out_valid_d[o] = 1'b1;
          rr_d[o]        = ~sel;
          pop[sel]       = 1'b1;
        end else begin
          out_valid_d[o] = 1'b0;
        end
      end
    end
  end

  // Output registers and arbitration pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= '0;
      rr_q        <= '0;
      for (int o = 0; o < 2; o++) out_flit_q[o] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rr_q        <= rr_d;
      for (int o = 0; o < 2; o++) out_flit_q[o] <= out_flit_d[o];
    end
  end

endmodule

// File: tb/tb_butterfly_switch_stage.sv
// Directed bench for butterfly_switch_stage (ADDR_W=3, LEVEL=1, DEPTH=4).
module tb_butterfly_switch_stage;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk, rst;
  logic [1:0]    in_valid, in_ready, out_valid, out_ready;
  logic [2*AW-1:0] in_src, in_dest, out_src, out_dest;
  logic [2*DW-1:0] in_data, out_data;
  logic [2*CW-1:0] fifo_cnt;
  logic [1:0]    m1_in_ready, m1_out_valid;
  logic [2*AW-1:0] m1_out_src, m1_out_dest;
  logic [2*DW-1:0] m1_out_data;
  logic [2*CW-1:0] m1_fifo_cnt;

  int n_chk = 0;
  int n_pass = 0;

  butterfly_switch_stage #(.ADDR_W(AW), .LEVEL(1), .DATA_W(DW), .DEPTH(4), .ROUTE_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
    .in_dest(in_dest), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_dest(out_dest), .out_data(out_data), .fifo_cnt(fifo_cnt)
  );

  butterfly_switch_stage #(.ADDR_W(AW), .LEVEL(1), .DATA_W(DW), .DEPTH(4), .ROUTE_MODE(1)) u_dut_m1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m1_in_ready), .in_src(in_src),
    .in_dest(in_dest), .in_data(in_data), .out_valid(m1_out_valid), .out_ready(out_ready),
    .out_src(m1_out_src), .out_dest(m1_out_dest), .out_data(m1_out_data), .fifo_cnt(m1_fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [2:0] s, input logic [2:0] d,
                        input logic [31:0] data);
    in_valid[i]          = v;
    in_src[i*AW +: AW]   = s;
    in_dest[i*AW +: AW]  = d;
    in_data[i*DW +: DW]  = data;
  endtask

  logic [31:0] exp_seq [8];
  int accepted, k, seen, guard;
  logic rdy;

  initial begin
    rst = 1'b0; in_valid = '0; in_src = '0; in_dest = '0; in_data = '0; out_ready = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd3);
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_addr", 64'({out_src, out_dest}), 64'd0);

    // single flit: xor routing sends src=000,dest=010 to output 1
    out_ready = 2'b11;
    set_in(0, 1'b1, 3'b000, 3'b010, 32'hA5);
    tick();
    set_in(0, 1'b0, 3'b000, 3'b000, 32'h0);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    check("lat_fifo_cnt0", 64'(fifo_cnt[2:0]), 64'd1);
    tick();
    check("lat_out_valid", 64'(out_valid), 64'b10);
    check("lat_out_data", 64'(out_data[63:32]), 64'hA5);
    check("lat_out_dest", 64'(out_dest[5:3]), 64'b010);
    tick();
    check("lat_drained", 64'(out_valid), 64'd0);

    // both inputs to output 0: strict alternation starting at input 0
    for (int j = 0; j < 8; j++) exp_seq[j] = ((j % 2 == 0) ? 32'h100 : 32'h200) + 32'(j / 2);
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        set_in(0, 1'b1, 3'b000, 3'b000, 32'h100 + 32'(c));
        set_in(1, 1'b1, 3'b000, 3'b000, 32'h200 + 32'(c));
      end else begin
        in_valid = '0;
      end
      tick();
      if (c >= 1 && c <= 8) begin
        check($sformatf("rr_valid_%0d", c - 1), 64'(out_valid[0]), 64'd1);
        check($sformatf("rr_data_%0d", c - 1), 64'(out_data[31:0]), 64'(exp_seq[c - 1]));
      end
    end
    check("rr_done", 64'(out_valid), 64'd0);

    // backpressure on output 1: 1 in the output register plus 4 in the FIFO
    out_ready = 2'b01;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      set_in(0, 1'b1, 3'b000, 3'b010, 32'h300 + 32'(accepted));
      rdy = in_ready[0];
      tick();
      if (rdy) accepted++;
      if (c == 3) check("bp_stable_mid", 64'(out_data[63:32]), 64'h300);
    end
    set_in(0, 1'b0, 3'b000, 3'b000, 32'h0);
    check("bp_accepted", 64'(accepted), 64'd5);
    check("bp_in_ready", 64'(in_ready[0]), 64'd0);
    check("bp_fifo_cnt", 64'(fifo_cnt[2:0]), 64'd4);
    check("bp_out_valid", 64'(out_valid), 64'b10);
    check("bp_stable_end", 64'(out_data[63:32]), 64'h300);
    out_ready = 2'b11;
    k = 0;
    guard = 0;
    while (k < 5 && guard < 20) begin
      if (out_valid[1]) begin
        check($sformatf("bp_drain_%0d", k), 64'(out_data[63:32]), 64'h300 + 64'(k));
        k++;
      end
      tick();
      guard++;
    end
    check("bp_drain_count", 64'(k), 64'd5);
    check("bp_empty", 64'(out_valid), 64'd0);

    // different outputs granted in the same cycle
    set_in(0, 1'b1, 3'b000, 3'b000, 32'h400);
    set_in(1, 1'b1, 3'b000, 3'b010, 32'h500);
    tick();
    in_valid = '0;
    tick();
    check("par_valid", 64'(out_valid), 64'b11);
    check("par_data", out_data, {32'h500, 32'h400});
    tick();
    check("par_drained", 64'(out_valid), 64'd0);

    // reset mid-transfer discards buffered flits
    out_ready = 2'b00;
    for (int n = 0; n < 3; n++) begin
      set_in(0, 1'b1, 3'b000, 3'b000, 32'h600 + 32'(n));
      tick();
    end
    in_valid = '0;
    check("rst_mid_pre_cnt", 64'(fifo_cnt[2:0]), 64'd2);
    check("rst_mid_pre_valid", 64'(out_valid), 64'b01);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_cnt", 64'(fifo_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 2'b11;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (out_valid != 2'b00) seen++;
    end
    check("rst_mid_no_emerge", 64'(seen), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd3);

    // route mode: src=010,dest=010 goes to out0 in xor mode, out1 in dest mode
    set_in(0, 1'b1, 3'b010, 3'b010, 32'h700);
    tick();
    in_valid = '0;
    tick();
    check("mode0_port", 64'(out_valid), 64'b01);
    check("mode1_port", 64'(m1_out_valid), 64'b10);
    check("mode1_data", 64'(m1_out_data[63:32]), 64'h700);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
